// File: rtl/hist_eq_mapper_if.sv
// Bundle between the histogram block, the pixel source and the equaliser.
// Carries the CDF write port, the live pixel stream and the mapped output.
interface hist_eq_mapper_if #(
  parameter int CDF_W = 20
) ();
  logic             iCum_Wen;
  logic [7:0]       iCum_Addr;
  logic [CDF_W-1:0] iCum_Data;
  logic             iCum_Done;
  logic             iFval;
  logic             iDval;
  logic [11:0]      iGrey;
  logic [11:0]      oEq_Grey;
  logic             oDval;
  logic             oFval;
  logic             oLut_Ready;
  logic             oOverrun;

  modport master (
    output iCum_Wen, iCum_Addr, iCum_Data, iCum_Done,
    output iFval, iDval, iGrey,
    input  oEq_Grey, oDval, oFval, oLut_Ready, oOverrun
  );

  modport slave (
    input  iCum_Wen, iCum_Addr, iCum_Data, iCum_Done,
    input  iFval, iDval, iGrey,
    output oEq_Grey, oDval, oFval, oLut_Ready, oOverrun
  );
endinterface

// File: rtl/hist_eq_mapper.sv
// Histogram-equalisation mapper: captures a CDF, scales it into a shadow
// LUT, swaps banks at frame start and maps the grey stream (2-cycle latency).
// Ports: iPclk, iRST_N (async low), bus (slave: CDF write, pixels, result).
module hist_eq_mapper #(
  parameter int unsigned SCALE_MUL   = 13926,
  parameter int unsigned SCALE_SHIFT = 24,
  parameter int unsigned CDF_W       = 20
) (
  input  logic            iPclk,
  input  logic            iRST_N,
  hist_eq_mapper_if.slave bus
);

  localparam int unsigned PW = CDF_W + 16;

  typedef enum logic [1:0] {
    LOAD,
    SCALE,
    WAIT_SWAP
  } state_e;

  state_e state_q, state_d;

  logic [CDF_W-1:0] cap_mem [256];
  logic [7:0]       lut_mem [512];

  logic          sel_q, sel_d;
  logic          rdy_q, rdy_d;
  logic          ovr_q, ovr_d;
  logic [8:0]    scnt_q, scnt_d;

  logic          v1_q, v2_q;
  logic [7:0]    idx1_q, idx2_q;
  logic [CDF_W-1:0] cap_rd_q;
  logic [PW-1:0] prod_q;
  logic [PW-1:0] shf;
  logic [7:0]    lut_val;

  logic [11:0]   grey1_q;
  logic          dval1_q, fval1_q, rdy1_q;
  logic [7:0]    lut_rd_q;
  logic [11:0]   eq_q;
  logic          dval_o_q, fval_o_q;

  logic          issue;
  logic          last_wr;
  logic          fval_rise;

  wire [PW-1:0] mul_c = PW'(SCALE_MUL);

  assign issue     = (state_q == SCALE) && !scnt_q[8];
  assign last_wr   = v2_q && (idx2_q == 8'hFF);
  // fval1_q is iFval one clock ago
  assign fval_rise = bus.iFval && !fval1_q;

  assign shf     = prod_q >> SCALE_SHIFT;
  assign lut_val = (|shf[PW-1:8]) ? 8'hFF : shf[7:0];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rdy_d   = rdy_q;
    scnt_d  = scnt_q;
    ovr_d   = ovr_q | (bus.iCum_Done && (state_q != LOAD));
    unique case (state_q)
      LOAD: begin
        scnt_d = '0;
        if (bus.iCum_Done) state_d = SCALE;
      end
      SCALE: begin
        if (issue) scnt_d = scnt_q + 9'd1;
        if (last_wr) state_d = WAIT_SWAP;
      end
      WAIT_SWAP: begin
        if (fval_rise) begin
          sel_d   = ~sel_q;
          rdy_d   = 1'b1;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge iPclk or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= LOAD;
      sel_q    <= 1'b0;
      rdy_q    <= 1'b0;
      ovr_q    <= 1'b0;
      scnt_q   <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      idx1_q   <= '0;
      idx2_q   <= '0;
      grey1_q  <= '0;
      dval1_q  <= 1'b0;
      fval1_q  <= 1'b0;
      rdy1_q   <= 1'b0;
      eq_q     <= '0;
      dval_o_q <= 1'b0;
      fval_o_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rdy_q    <= rdy_d;
      ovr_q    <= ovr_d;
      scnt_q   <= scnt_d;
      v1_q     <= issue;
      idx1_q   <= scnt_q[7:0];
      v2_q     <= v1_q;
      idx2_q   <= idx1_q;
      grey1_q  <= bus.iGrey;
      dval1_q  <= bus.iDval;
      fval1_q  <= bus.iFval;
      // ready that goes with the bank used by this pixel's read
      rdy1_q   <= rdy_d;
      eq_q     <= rdy1_q ? {lut_rd_q, 4'h0} : grey1_q;
      dval_o_q <= dval1_q;
      fval_o_q <= fval1_q;
    end
  end

  // Storage and scale datapath; RAM contents survive reset.
  always_ff @(posedge iPclk) begin
    if ((state_q == LOAD) && bus.iCum_Wen)
      cap_mem[bus.iCum_Addr] <= bus.iCum_Data;
    cap_rd_q <= cap_mem[scnt_q[7:0]];
    prod_q   <= PW'(cap_rd_q) * mul_c;
    if (v2_q)
      lut_mem[{~sel_q, idx2_q}] <= lut_val;
    // read with the next bank select so a swapping edge uses the new bank
    lut_rd_q <= lut_mem[{sel_d, bus.iGrey[11:4]}];
  end

  assign bus.oEq_Grey   = eq_q;
  assign bus.oDval      = dval_o_q;
  assign bus.oFval      = fval_o_q;
  assign bus.oLut_Ready = rdy_q;
  assign bus.oOverrun   = ovr_q;

endmodule
